// File: rtl/app_switcher_pkg.sv
// rtl/app_switcher_pkg.sv - shared encodings and constants for app_switcher
//
// Purpose: mode encodings, blanked-output constants and the sound wake
// threshold shared by app_switcher, idle_timer and the bench.
// Ports:   none (package).

package app_switcher_pkg;

  typedef enum logic [1:0] {
    MODE_MENU  = 2'd0,
    MODE_APP   = 2'd1,
    MODE_SAVER = 2'd2,
    MODE_BLANK = 2'd3
  } mode_t;

  // Board pins are active-low, so "all off" is all ones.
  localparam logic [3:0] AN_OFF   = 4'hF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Volume level at or above which sound counts as user activity.
  localparam logic [3:0] WAKE_LVL = 4'd8;

  // True for the interactive modes that can idle into the screen saver.
  function automatic logic is_interactive(input mode_t m);
    return (m == MODE_MENU) || (m == MODE_APP);
  endfunction

endpackage

// File: rtl/app_switcher_if.sv
// rtl/app_switcher_if.sv - channel inputs, user events and board outputs of app_switcher
//
// Purpose: bundles everything except clk/reset that crosses the app_switcher
//          boundary.
// Ports (signals):
//   sec_tick, bC, bL, bR, bU, bD  single-cycle event pulses
//   vol_lvl                       current volume level
//   oled_in/an_in/seg_in/led_in   per-channel data, channel k in slice k
//   mode, cursor                  switcher state
//   oled_data, an, seg, led       registered board outputs
// Modports: master drives events/channels and reads outputs; slave is the switcher.

interface app_switcher_if #(
  parameter int N_APPS = 6,
  parameter int CH_W   = $clog2(N_APPS)
);

  logic                  sec_tick;
  logic                  bC, bL, bR, bU, bD;
  logic [3:0]            vol_lvl;
  logic [16*N_APPS-1:0]  oled_in;
  logic [4*N_APPS-1:0]   an_in;
  logic [8*N_APPS-1:0]   seg_in;
  logic [16*N_APPS-1:0]  led_in;

  logic [1:0]            mode;
  logic [CH_W-1:0]       cursor;
  logic [15:0]           oled_data;
  logic [3:0]            an;
  logic [7:0]            seg;
  logic [15:0]           led;

  modport master (
    output sec_tick, bC, bL, bR, bU, bD, vol_lvl,
    output oled_in, an_in, seg_in, led_in,
    input  mode, cursor, oled_data, an, seg, led
  );

  modport slave (
    input  sec_tick, bC, bL, bR, bU, bD, vol_lvl,
    input  oled_in, an_in, seg_in, led_in,
    output mode, cursor, oled_data, an, seg, led
  );

endinterface

// File: rtl/app_switcher_idle_timer.sv
// rtl/app_switcher_idle_timer.sv - saturating idle-seconds counter
//
// Purpose: counts sec_tick pulses since the last user activity, saturating at
//          POWER_SECS, and flags the saver and power-off thresholds.
// Ports:
//   clk, reset  clock, async active-high reset
//   clr         user activity this cycle; clears the count (wins over tick)
//   tick        one-second pulse
//   sat_saver   count >= SAVER_SECS
//   sat_power   count == POWER_SECS

module idle_timer #(
  parameter int SAVER_SECS = 30,
  parameter int POWER_SECS = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic sat_saver,
  output logic sat_power
);

  localparam int CNT_W = $clog2(POWER_SECS + 1);
  localparam logic [CNT_W-1:0] SAVER_CNT = CNT_W'(SAVER_SECS);
  localparam logic [CNT_W-1:0] POWER_CNT = CNT_W'(POWER_SECS);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (tick && (count_q != POWER_CNT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign sat_saver = (count_q >= SAVER_CNT);
  assign sat_power = (count_q == POWER_CNT);

endmodule

// File: rtl/app_switcher.sv
// rtl/app_switcher.sv - menu/application channel switcher with idle saver and blanking
//
// Purpose: selects one of N_APPS application channels (channel 0 = menu) and
//          registers it onto the OLED, 7-segment and LED outputs; owns menu
//          navigation and idle-driven SAVER/BLANK modes.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    app_switcher_if.slave (events, channel inputs, board outputs)
// Optional: define WAKE_ON_SOUND_EN to treat vol_lvl >= WAKE_LVL as user activity.

module app_switcher
  import app_switcher_pkg::*;
#(
  parameter int N_APPS     = 6,
  parameter int SAVER_CH   = N_APPS - 1,
  parameter int SAVER_SECS = 30,
  parameter int POWER_SECS = 60,
  parameter int CH_W       = $clog2(N_APPS)
) (
  input  logic          clk,
  input  logic          reset,
  app_switcher_if.slave bus
);

  localparam logic [CH_W-1:0] FIRST_APP = CH_W'(1);
  localparam logic [CH_W-1:0] LAST_APP  = CH_W'(N_APPS - 1);
  localparam logic [CH_W-1:0] SAVER_IDX = CH_W'(SAVER_CH);
  localparam logic [CH_W-1:0] MENU_IDX  = '0;

  mode_t           mode_q;
  mode_t           prev_q;
  logic [CH_W-1:0] cursor_q;
  logic            woke_q;      // previous cycle was a wake; swallow navigation
  logic            any_btn;
  logic            activity;
  logic            sat_saver;
  logic            sat_power;
  logic [CH_W-1:0] cur_inc;
  logic [CH_W-1:0] cur_dec;
  logic [CH_W-1:0] sel_ch;

  logic [15:0] oled_q;
  logic [3:0]  an_q;
  logic [7:0]  seg_q;
  logic [15:0] led_q;

  assign any_btn = bus.bC | bus.bL | bus.bR | bus.bU | bus.bD;

`ifdef WAKE_ON_SOUND_EN
  assign activity = any_btn | (bus.vol_lvl >= WAKE_LVL);
`else
  logic unused_vol;
  assign unused_vol = ^bus.vol_lvl;
  assign activity   = any_btn;
`endif

  idle_timer #(
    .SAVER_SECS(SAVER_SECS),
    .POWER_SECS(POWER_SECS)
  ) u_idle_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (activity),
    .tick      (bus.sec_tick),
    .sat_saver (sat_saver),
    .sat_power (sat_power)
  );

  // Cursor walks only over application channels 1..N_APPS-1.
  assign cur_inc = (cursor_q == LAST_APP)  ? FIRST_APP : cursor_q + CH_W'(1);
  assign cur_dec = (cursor_q == FIRST_APP) ? LAST_APP  : cursor_q - CH_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_MENU;
      prev_q   <= MODE_MENU;
      cursor_q <= FIRST_APP;
      woke_q   <= 1'b0;
    end else begin
      woke_q <= 1'b0;
      case (mode_q)
        MODE_MENU: begin
          if (activity) begin
            if (!woke_q) begin
              if (bus.bC)      mode_q   <= MODE_APP;
              else if (bus.bL) cursor_q <= cur_dec;
              else if (bus.bR) cursor_q <= cur_inc;
            end
          end else if (sat_saver) begin
            prev_q <= MODE_MENU;
            mode_q <= MODE_SAVER;
          end
        end
        MODE_APP: begin
          if (activity) begin
            if (!woke_q && bus.bC) mode_q <= MODE_MENU;
          end else if (sat_saver) begin
            prev_q <= MODE_APP;
            mode_q <= MODE_SAVER;
          end
        end
        MODE_SAVER: begin
          if (activity) begin
            mode_q <= prev_q;
            woke_q <= 1'b1;
          end else if (sat_power) begin
            mode_q <= MODE_BLANK;
          end
        end
        MODE_BLANK: begin
          if (activity) begin
            mode_q <= prev_q;
            woke_q <= 1'b1;
          end
        end
        default: mode_q <= MODE_MENU;
      endcase
    end
  end

  always_comb begin
    sel_ch = MENU_IDX;
    case (mode_q)
      MODE_APP:   sel_ch = cursor_q;
      MODE_SAVER: sel_ch = SAVER_IDX;
      default:    sel_ch = MENU_IDX;
    endcase
  end

  // Output stage follows the registered mode, so a mode change shows up
  // on the pins one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oled_q <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      led_q  <= '0;
    end else if (mode_q == MODE_BLANK) begin
      oled_q <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      led_q  <= '0;
    end else begin
      oled_q <= bus.oled_in[16*sel_ch +: 16];
      an_q   <= bus.an_in[4*sel_ch +: 4];
      seg_q  <= bus.seg_in[8*sel_ch +: 8];
      led_q  <= bus.led_in[16*sel_ch +: 16];
    end
  end

  assign bus.mode      = mode_q;
  assign bus.cursor    = cursor_q;
  assign bus.oled_data = oled_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.led       = led_q;

endmodule

// File: tb/tb_app_switcher.sv
// tb/tb_app_switcher.sv - self-checking bench for app_switcher

module tb_app_switcher;

  localparam int N    = 6;
  localparam int SAVE = 30;
  localparam int PWR  = 60;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   cmp_en;

  logic [15:0] pix [N];
  logic [3:0]  anv [N];
  logic [7:0]  segv[N];
  logic [15:0] ledv[N];

  app_switcher_if #(.N_APPS(N)) bus ();

  app_switcher #(.N_APPS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    bus.oled_in = '0;
    bus.an_in   = '0;
    bus.seg_in  = '0;
    bus.led_in  = '0;
    for (int k = 0; k < N; k++) begin
      bus.oled_in[16*k +: 16] = pix[k];
      bus.an_in[4*k +: 4]     = anv[k];
      bus.seg_in[8*k +: 8]    = segv[k];
      bus.led_in[16*k +: 16]  = ledv[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode is 0=menu 1=app 2=saver 3=blank; idle_secs is
  // seconds since last activity. Decisions at an edge use the idle seconds
  // already counted before that edge; the pins show what the mode selected
  // before the edge.
  int          m_mode, m_prev, m_cursor, idle_secs;
  bit          m_woke;
  logic [15:0] e_oled;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic [15:0] e_led;

  always @(posedge clk or posedge reset) begin
    int  ch;
    bit  btn, act, woke_now;
    if (reset) begin
      m_mode = 0; m_prev = 0; m_cursor = 1; idle_secs = 0; m_woke = 0;
      e_oled = 16'h0; e_an = 4'hF; e_seg = 8'hFF; e_led = 16'h0;
    end else begin
      if (m_mode == 3) begin
        e_oled = 16'h0; e_an = 4'hF; e_seg = 8'hFF; e_led = 16'h0;
      end else begin
        ch = (m_mode == 0) ? 0 : (m_mode == 1) ? m_cursor : N - 1;
        e_oled = pix[ch]; e_an = anv[ch]; e_seg = segv[ch]; e_led = ledv[ch];
      end
      btn = bus.bC | bus.bL | bus.bR | bus.bU | bus.bD;
      act = btn;
`ifdef WAKE_ON_SOUND_EN
      if (bus.vol_lvl >= 4'd8) act = 1'b1;
`endif
      woke_now = 0;
      if (m_mode <= 1) begin
        if (act) begin
          if (!m_woke) begin
            if (bus.bC) m_mode = 1 - m_mode;
            else if (m_mode == 0 && bus.bL) m_cursor = ((m_cursor + N - 3) % (N - 1)) + 1;
            else if (m_mode == 0 && bus.bR) m_cursor = (m_cursor % (N - 1)) + 1;
          end
        end else if (idle_secs >= SAVE) begin
          m_prev = m_mode;
          m_mode = 2;
        end
      end else if (act) begin
        m_mode = m_prev;
        woke_now = 1;
      end else if (m_mode == 2 && idle_secs >= PWR) begin
        m_mode = 3;
      end
      m_woke = woke_now;
      if (act) idle_secs = 0;
      else if (bus.sec_tick && idle_secs < PWR) idle_secs = idle_secs + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mode",   32'(bus.mode),      32'(m_mode));
      check("cursor", 32'(bus.cursor),    32'(m_cursor));
      check("oled",   32'(bus.oled_data), 32'(e_oled));
      check("an",     32'(bus.an),        32'(e_an));
      check("seg",    32'(bus.seg),       32'(e_seg));
      check("led",    32'(bus.led),       32'(e_led));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit c, input bit l, input bit r, input bit u, input bit d);
    bus.bC = c; bus.bL = l; bus.bR = r; bus.bU = u; bus.bD = d;
    cyc(1);
    bus.bC = 0; bus.bL = 0; bus.bR = 0; bus.bU = 0; bus.bD = 0;
  endtask

  task automatic secs(input int n);
    repeat (n) begin
      bus.sec_tick = 1'b1;
      cyc(1);
      bus.sec_tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 0;
    reset = 1'b0;
    bus.sec_tick = 0; bus.vol_lvl = 4'd0;
    bus.bC = 0; bus.bL = 0; bus.bR = 0; bus.bU = 0; bus.bD = 0;
    for (int k = 0; k < N; k++) begin
      pix[k]  = 16'h1111 * 16'(k) + 16'h0100;
      anv[k]  = 4'(k);
      segv[k] = 8'h30 + 8'(k);
      ledv[k] = 16'h8000 >> k;
    end
    #1 reset = 1'b1;
    cmp_en = 1;
    #2;
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_cursor", 32'(bus.cursor), 32'd1);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'hFF);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // bR x3 then bC -> app 4
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    check("app4_mode", 32'(bus.mode), 32'd1);
    check("app4_cursor", 32'(bus.cursor), 32'd4);
    cyc(1);
    check("app4_oled", 32'(bus.oled_data), 32'h4544);

    // Wrap both directions
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    check("cur5", 32'(bus.cursor), 32'd5);
    press(0, 0, 1, 0, 0);
    check("wrap_up", 32'(bus.cursor), 32'd1);
    press(0, 1, 0, 0, 0);
    check("wrap_down", 32'(bus.cursor), 32'd5);
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    check("app2_mode", 32'(bus.mode), 32'd1);

    // Idle from APP into SAVER, then BLANK
    secs(SAVE - 1);
    check("pre_saver", 32'(bus.mode), 32'd1);
    secs(1);
    check("saver_mode", 32'(bus.mode), 32'd2);
    cyc(1);
    check("saver_oled", 32'(bus.oled_data), 32'h5655);
    secs(PWR - SAVE);
    check("blank_mode", 32'(bus.mode), 32'd3);
    cyc(1);
    check("blank_an", 32'(bus.an), 32'hF);
    check("blank_seg", 32'(bus.seg), 32'hFF);
    check("blank_led", 32'(bus.led), 32'h0);
    check("blank_oled", 32'(bus.oled_data), 32'h0);

    // Wake with bC: back to APP, following bC swallowed, later bC -> MENU
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    check("wake_mode", 32'(bus.mode), 32'd1);
    check("wake_cursor", 32'(bus.cursor), 32'd2);
    cyc(2);
    press(1, 0, 0, 0, 0);
    check("menu_again", 32'(bus.mode), 32'd0);

    // bC and bR together: bC wins
    press(1, 0, 1, 0, 0);
    check("prio_mode", 32'(bus.mode), 32'd1);
    check("prio_cursor", 32'(bus.cursor), 32'd2);
    press(1, 0, 0, 0, 0);

    // sec_tick coincident with bU clears the counter
    secs(3);
    bus.sec_tick = 1'b1; bus.bU = 1'b1;
    cyc(1);
    bus.sec_tick = 1'b0; bus.bU = 1'b0;
    cyc(1);
    secs(SAVE - 1);
    check("tick_btn_menu", 32'(bus.mode), 32'd0);
    secs(1);
    check("tick_btn_saver", 32'(bus.mode), 32'd2);

`ifdef WAKE_ON_SOUND_EN
    bus.vol_lvl = 4'd7;
    cyc(3);
    check("vol7_saver", 32'(bus.mode), 32'd2);
    bus.vol_lvl = 4'd9;
    cyc(1);
    bus.vol_lvl = 4'd0;
    check("vol9_wake", 32'(bus.mode), 32'd0);
`else
    bus.vol_lvl = 4'd15;
    cyc(3);
    check("vol_ignored", 32'(bus.mode), 32'd2);
    bus.vol_lvl = 4'd0;
    press(0, 0, 0, 0, 1);
    check("bd_wake", 32'(bus.mode), 32'd0);
`endif
    cyc(2);

    // Channel data change reaches the pins one clock later
    pix[0] = 16'hBEEF;
    cyc(1);
    check("latency", 32'(bus.oled_data), 32'hBEEF);

    // Async reset mid-operation
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    cyc(1);
    #2 reset = 1'b1;
    #1;
    check("areset_mode", 32'(bus.mode), 32'd0);
    check("areset_cursor", 32'(bus.cursor), 32'd1);
    check("areset_oled", 32'(bus.oled_data), 32'h0);
    check("areset_seg", 32'(bus.seg), 32'hFF);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/app_switcher.md
Name: app_switcher

Overview:
- Parametrised successor to the fixed application state controller.
- Selects one of N_APPS application channels (OLED pixel, anode, segment, LED) and registers the selected channel onto the board outputs.
- Owns menu navigation and an idle timer that drives screen-saver and power-saving modes.
- Sits between the per-application modules and the OLED, 7-segment and LED pins, in place of the hard-coded menu and state control.

Parameters:
- N_APPS, 6, number of channels; channel 0 is the menu, channels 1..N_APPS-1 are applications (N_APPS >= 3).
- SAVER_CH, N_APPS-1, channel shown in SAVER mode.
- SAVER_SECS, 30, idle seconds before entering SAVER.
- POWER_SECS, 60, idle seconds before entering BLANK (POWER_SECS > SAVER_SECS).
- CH_W, $clog2(N_APPS), width of the channel index.

Ports:
- clk  in  1  system clock; only clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse once per second, synchronous to clk.
- bC, bL, bR, bU, bD  in  1 each  single-cycle button pulses, synchronous to clk.
- oled_in  in  16*N_APPS  pixel per channel; channel k occupies bits [16k+15:16k].
- an_in  in  4*N_APPS  anodes per channel.
- seg_in  in  8*N_APPS  segments per channel.
- led_in  in  16*N_APPS  LEDs per channel.
- vol_lvl  in  4  current volume level; used only with WAKE_ON_SOUND_EN.
- mode  out  2  0=MENU, 1=APP, 2=SAVER, 3=BLANK.
- cursor  out  CH_W  highlighted or active application index.
- oled_data  out  16  registered selected pixel.
- an  out  4  registered selected anodes.
- seg  out  8  registered selected segments.
- led  out  16  registered selected LEDs.

Behaviour:
- Reset values:
  - mode=MENU, cursor=1, idle counter=0.
  - oled_data=0, an=4'hF, seg=8'hFF, led=0.
  - prev_mode=MENU.
- Selected channel by mode:
  - MENU selects channel 0.
  - APP selects channel `cursor`.
  - SAVER selects channel SAVER_CH.
  - BLANK selects no channel; outputs are forced to the reset values.
- Output latency: outputs are registered copies of the selected channel, one clk after the inputs or the mode change.
- Any button = bC|bL|bR|bU|bD.
- Idle counter:
  - Clears to 0 on any button.
  - Otherwise increments on sec_tick.
  - Saturates at POWER_SECS.
- MENU:
  - bL decrements cursor; 1 wraps to N_APPS-1.
  - bR increments cursor; N_APPS-1 wraps to 1.
  - bC sets mode=APP.
  - Priority when buttons coincide in the same cycle: bC > bL > bR.
  - bU and bD are ignored by this block; they still clear the idle counter.
- APP:
  - bC returns to MENU with cursor unchanged.
  - bL and bR are ignored; applications consume them.
- Idle transitions (MENU or APP):
  - When the counter reaches SAVER_SECS, save prev_mode and set mode=SAVER.
  - In SAVER, when the counter reaches POWER_SECS, set mode=BLANK.
- Wake from SAVER or BLANK:
  - Any button restores mode=prev_mode and clears the counter.
  - The waking button is consumed; it causes no navigation in the same or the next cycle.
- Simultaneous sec_tick and button in one cycle: the button wins and the counter becomes 0.
- Asynchronous reset asserted mid-operation returns every register to its reset value immediately.
- cursor never takes the value 0 or any value >= N_APPS.

Optional Feature:
- Macro WAKE_ON_SOUND_EN.
- When defined:
  - vol_lvl >= 8 in SAVER or BLANK wakes exactly as a button does.
  - vol_lvl >= 8 also clears the idle counter in MENU and APP.
- When undefined: vol_lvl is unused and only buttons wake or clear.

Decomposition:
- Shared package/header holds:
  - Mode encodings MODE_MENU, MODE_APP, MODE_SAVER, MODE_BLANK.
  - Blank output constants AN_OFF=4'hF, SEG_OFF=8'hFF.
  - Wake threshold WAKE_LVL=8.
- One sub-module, idle_timer: saturating seconds counter with clear input and sat_saver / sat_power flags.
- The mode FSM and the output mux stay in app_switcher.

Test Plan:
- Reset, then bR three times, then bC with N_APPS=6 -> cursor=4, mode=APP; the cycle after, oled_data equals channel 4's pixel.
- In MENU with cursor=5, bR -> cursor=1; bL -> cursor=5 (wrap in both directions).
- No buttons for 30 sec_ticks from APP -> mode=SAVER, oled shows channel 5; 30 more ticks -> mode=BLANK, an=F, seg=FF, led=0, oled=0.
- In BLANK, pulse bC -> mode=APP (prev_mode), cursor unchanged, no return to MENU; the next bC goes to MENU.
- bC and bR in the same cycle in MENU -> mode=APP, cursor unchanged; sec_tick coincident with bU -> counter=0.
- With WAKE_ON_SOUND_EN defined, in SAVER set vol_lvl=9 -> prev_mode restored; vol_lvl=7 -> stays in SAVER. Without the macro, vol_lvl=15 -> no effect.
